// File: rtl/seq_unsigned_divider64_32_if.sv
// Start/result handshake bundle for the sequential unsigned divider.
// The bench drives the master side and the divider implements the slave side.
interface seq_unsigned_divider64_32_if #(
  parameter int DIVIDEND_W = 64,
  parameter int DIVISOR_W  = 32
);
  logic                  start_valid;
  logic                  start_ready;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  result_valid;
  logic                  result_ready;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  div_by_zero;
  logic                  busy;

  modport master (
    output start_valid, dividend, divisor, result_ready,
    input  start_ready, result_valid, quotient, remainder, div_by_zero, busy
  );

  modport slave (
    input  start_valid, dividend, divisor, result_ready,
    output start_ready, result_valid, quotient, remainder, div_by_zero, busy
  );
endinterface

// File: rtl/seq_unsigned_divider64_32.sv
// Iterative restoring unsigned divider: one quotient bit per clock from a single
// (DIVISOR_W+1)-bit subtractor, with valid/ready start and result handshakes.
module seq_unsigned_divider64_32 #(
  parameter int DIVIDEND_W = 64,
  parameter int DIVISOR_W  = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  seq_unsigned_divider64_32_if.slave  div_if
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DIVIDEND_W-1:0] r_shift;
  logic [DIVISOR_W-1:0]  r_rem;
  logic [DIVISOR_W-1:0]  r_dvsr;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_dbz;

  logic                  w_accept;
  logic                  w_start_ready;
  logic                  w_result_valid;
  logic                  w_busy;
  logic [DIVISOR_W:0]    w_shifted;
  logic [DIVISOR_W:0]    w_trial;
  logic                  w_borrow;

  // Partial remainder is always below the divisor, so the top bit of the
  // (DIVISOR_W+1)-bit difference is exactly the borrow.
  assign w_shifted = {r_rem, r_shift[DIVIDEND_W-1]};
  assign w_trial   = w_shifted - {1'b0, r_dvsr};
  assign w_borrow  = w_trial[DIVISOR_W];
  assign w_accept  = (r_state == IDLE) && div_if.start_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_start_ready  = 1'b0;
    w_result_valid = 1'b0;
    w_busy         = 1'b0;
    case (r_state)
      IDLE: begin
        w_start_ready = 1'b1;
        if (div_if.start_valid) begin
          w_state_nxt = (div_if.divisor == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        w_busy = 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_busy         = 1'b1;
        w_result_valid = 1'b1;
        if (div_if.result_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Divide-by-zero skips iteration and loads the flagged result directly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_rem   <= '0;
      r_dvsr  <= '0;
      r_cnt   <= '0;
      r_dbz   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_dvsr <= div_if.divisor;
            r_cnt  <= CNT_W'(DIVIDEND_W);
            if (div_if.divisor == '0) begin
              r_shift <= '1;
              r_rem   <= div_if.dividend[DIVISOR_W-1:0];
              r_dbz   <= 1'b1;
            end else begin
              r_shift <= div_if.dividend;
              r_rem   <= '0;
              r_dbz   <= 1'b0;
            end
          end
        end
        CALC: begin
          r_shift <= {r_shift[DIVIDEND_W-2:0], ~w_borrow};
          r_rem   <= w_borrow ? w_shifted[DIVISOR_W-1:0] : w_trial[DIVISOR_W-1:0];
          r_cnt   <= r_cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign div_if.start_ready  = w_start_ready;
  assign div_if.result_valid = w_result_valid;
  assign div_if.busy         = w_busy;
  assign div_if.quotient     = r_shift;
  assign div_if.remainder    = r_rem;
  assign div_if.div_by_zero  = r_dbz;

endmodule

// File: tb/tb_seq_unsigned_divider64_32.sv
// Directed and randomized bench for the sequential divider against an
// arithmetic reference (plain / and %).
module tb_seq_unsigned_divider64_32;
  localparam int DW = 64;
  localparam int SW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  seq_unsigned_divider64_32_if #(.DIVIDEND_W(DW), .DIVISOR_W(SW)) bus ();

  seq_unsigned_divider64_32 #(.DIVIDEND_W(DW), .DIVISOR_W(SW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .div_if (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void ref_div(input logic [63:0] a, input logic [31:0] b,
                                  output logic [63:0] q, output logic [31:0] r);
    if (b == 32'd0) begin
      q = '1;
      r = a[31:0];
    end else begin
      q = a / {32'd0, b};
      r = 32'(a % {32'd0, b});
    end
  endfunction

  task automatic run_div(input logic [63:0] a, input logic [31:0] b, input int bp, input string tag);
    logic [63:0] eq;
    logic [31:0] er;
    logic        edbz;
    int          n;
    ref_div(a, b, eq, er);
    edbz = (b == 32'd0);
    n = 0;
    while (!bus.start_ready && n < 100) begin
      tick();
      n++;
    end
    chk({tag, " start_ready"}, 64'(bus.start_ready), 64'd1);
    bus.result_ready = (bp == 0);
    bus.start_valid  = 1'b1;
    bus.dividend     = a;
    bus.divisor      = b;
    tick();
    bus.start_valid = 1'b0;
    bus.dividend    = {$urandom, $urandom};
    bus.divisor     = $urandom;
    n = 1;
    while (!bus.result_valid && n < 200) begin
      tick();
      n++;
    end
    chk({tag, " latency"}, 64'(n), edbz ? 64'd1 : 64'd65);
    chk({tag, " quotient"}, bus.quotient, eq);
    chk({tag, " remainder"}, 64'(bus.remainder), 64'(er));
    chk({tag, " div_by_zero"}, 64'(bus.div_by_zero), 64'(edbz));
    for (int i = 0; i < bp; i++) begin
      bus.start_valid = i[0];
      bus.dividend    = {$urandom, $urandom};
      bus.divisor     = $urandom;
      tick();
      chk({tag, " hold quotient"}, bus.quotient, eq);
      chk({tag, " hold remainder"}, 64'(bus.remainder), 64'(er));
      chk({tag, " hold valid"}, 64'(bus.result_valid), 64'd1);
      chk({tag, " hold start_ready"}, 64'(bus.start_ready), 64'd0);
    end
    bus.start_valid  = 1'b0;
    bus.result_ready = 1'b1;
    tick();
    chk({tag, " valid after handshake"}, 64'(bus.result_valid), 64'd0);
    chk({tag, " start_ready after handshake"}, 64'(bus.start_ready), 64'd1);
    chk({tag, " quotient kept"}, bus.quotient, eq);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " start_ready"}, 64'(bus.start_ready), 64'd1);
    chk({tag, " result_valid"}, 64'(bus.result_valid), 64'd0);
    chk({tag, " busy"}, 64'(bus.busy), 64'd0);
    chk({tag, " quotient"}, bus.quotient, 64'd0);
    chk({tag, " remainder"}, 64'(bus.remainder), 64'd0);
    chk({tag, " div_by_zero"}, 64'(bus.div_by_zero), 64'd0);
  endtask

  initial begin
    logic [63:0] ra;
    logic [31:0] rb;
    logic        seen_valid;
    bus.start_valid  = 1'b0;
    bus.dividend     = '0;
    bus.divisor      = '0;
    bus.result_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) tick();
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    run_div(64'd100, 32'd7, 0, "d100_7");
    run_div(64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 0, "dmax_max");
    run_div(64'hFFFF_FFFF_FFFF_FFFF, 32'd1, 0, "dmax_1");
    run_div(64'd5, 32'd9, 0, "d5_9");
    run_div(64'd0, 32'd3, 0, "d0_3");
    run_div(64'h1234_5678_9ABC_DEF0, 32'd0, 0, "dzero");
    run_div(64'd77, 32'd5, 0, "d77_5");
    run_div(64'd1000, 32'd10, 12, "dbackpressure");

    // Abort on the edge that would perform iteration 30.
    bus.result_ready = 1'b1;
    bus.start_valid  = 1'b1;
    bus.dividend     = 64'd100;
    bus.divisor      = 32'd7;
    tick();
    bus.start_valid = 1'b0;
    repeat (29) tick();
    chk("midcalc busy", 64'(bus.busy), 64'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_reset_outputs("midcalc reset");
    seen_valid = 1'b0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (bus.result_valid) seen_valid = 1'b1;
    end
    chk("midcalc no result", 64'(seen_valid), 64'd0);
    run_div(64'd100, 32'd7, 0, "d100_7_again");

    for (int k = 0; k < 20; k++) begin
      ra = {$urandom, $urandom} >> $urandom_range(0, 63);
      rb = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 9) == 0) rb = 32'd0;
      run_div(ra, rb, int'($urandom_range(0, 3)), $sformatf("rand%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_unsigned_divider64_32.md
Name: seq_unsigned_divider64_32

Overview:
- Iterative restoring unsigned divider for the arithmetic datapath. It is the inverse companion of the multiply/accumulate adder chain.
- Divides a DIVIDEND_W-bit dividend by a DIVISOR_W-bit divisor.
- Produces one quotient bit per clock from a single (DIVISOR_W+1)-bit subtractor.
- Operands are accepted through a valid/ready start handshake; quotient and remainder are returned through a valid/ready result handshake.

Parameters:
- DIVIDEND_W, 64, dividend and quotient width.
- DIVISOR_W, 32, divisor and remainder width; must be ≤ DIVIDEND_W.

Ports:
- clk  input  1  single clock; rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start_valid  input  1  operands present.
- start_ready  output  1  divider can accept operands.
- dividend  input  DIVIDEND_W  unsigned dividend.
- divisor  input  DIVISOR_W  unsigned divisor.
- result_valid  output  1  quotient/remainder valid.
- result_ready  input  1  consumer takes result.
- quotient  output  DIVIDEND_W  floor(dividend/divisor).
- remainder  output  DIVISOR_W  dividend mod divisor.
- div_by_zero  output  1  flags that the current result came from divisor==0.
- busy  output  1  high in CALC or DONE.

Behaviour:
- Reset: rst_n low at a rising edge forces the following, regardless of the current state:
  - state=IDLE, start_ready=1, result_valid=0, busy=0;
  - quotient=0, remainder=0, div_by_zero=0;
  - iteration counter=0, internal registers=0.
- Reset mid-CALC or mid-DONE aborts the operation. The pending result is discarded and never presented.
- States: IDLE, CALC, DONE.
- IDLE:
  - start_ready=1.
  - Accept occurs on an edge where start_valid&&start_ready.
  - On accept, capture dividend into the shift register, divisor into the divisor register, clear the partial remainder, and load counter=DIVIDEND_W.
  - If divisor==0, go to DONE with:
    - quotient = all ones;
    - remainder = dividend[DIVISOR_W-1:0];
    - div_by_zero=1.
  - Otherwise go to CALC with div_by_zero=0.
- CALC, one iteration per cycle:
  - trial = {partial_rem[DIVISOR_W-1:0], dividend_msb} − {1'b0, divisor}, computed in DIVISOR_W+1 bits.
  - If there is no borrow, partial_rem = trial and the quotient bit is 1.
  - If there is a borrow, partial_rem = shifted value and the quotient bit is 0.
  - The quotient bit shifts into the LSB of the dividend/quotient shift register. The counter decrements.
  - When the counter reaches 1 and that iteration completes, go to DONE.
- DONE:
  - result_valid=1, start_ready=0.
  - quotient, remainder and div_by_zero are held stable until result_ready is sampled high.
  - On the edge where result_valid&&result_ready: go to IDLE, result_valid=0.
  - quotient, remainder and div_by_zero keep their last values until the next accept.
- Latency:
  - Normal case: result_valid rises DIVIDEND_W+1 edges after the accept edge (65 for defaults).
  - divisor==0: result_valid rises 1 edge after the accept edge.
- No overlap: start_ready is 0 throughout CALC and DONE. start_valid is ignored outside IDLE.
- Input changes after the accept edge have no effect.
- start_ready rises in the cycle after the result handshake. Back-to-back issue therefore needs one IDLE cycle.
- Width rules:
  - The partial remainder never exceeds divisor−1, so it always fits DIVISOR_W bits.
  - The (DIVISOR_W+1)th bit exists only to detect the borrow.
  - No overflow is possible for any nonzero divisor.

Test Plan:
- 100 / 7, result_ready held high → quotient=14, remainder=2, div_by_zero=0. result_valid first high exactly 65 edges after accept; start_ready=1 one cycle after the handshake.
- 64'hFFFF_FFFF_FFFF_FFFF / 32'hFFFF_FFFF → quotient=64'h0000_0001_0000_0001, remainder=0. Then the same dividend / 1 → quotient=64'hFFFF_FFFF_FFFF_FFFF, remainder=0.
- 5 / 9 → quotient=0, remainder=5. 0 / 3 → quotient=0, remainder=0.
- 64'h1234_5678_9ABC_DEF0 / 0 → result_valid one edge after accept, quotient=all ones, remainder=32'h9ABC_DEF0, div_by_zero=1. The next normal divide returns div_by_zero=0.
- Backpressure: 1000 / 10 with result_ready held low 12 cycles after result_valid → quotient=100 and remainder=0 stable for all 12 cycles. start_ready stays 0, and start_valid pulses during this window are not accepted.
- Reset mid-CALC: assert rst_n=0 for one edge at iteration 30 → next cycle all outputs are at reset values, state=IDLE, and no result_valid pulse occurs. A fresh 100 / 7 then returns 14 r 2.
